// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial add/sub block: FSM state encoding and
// helpers that derive the chunk count and chunk-counter width.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of chunk cycles per operation (guarded so a bad CHUNK does not
    // divide by zero before the elaboration check reports it).
    function automatic int num_chunks(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // Width of the chunk counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_chunk_adder.sv
// CHUNK-bit ripple-carry adder slice. Exposes every bit's carry-out plus the
// carry into the top bit so the caller can form signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic [CHUNK-1:0] carry,
    output logic             c_msb_in
);

    // Ripple the carry bit by bit; a local variable carries the chain so the
    // carry vector never feeds back into itself.
    always_comb begin
        logic c_run;
        c_run    = cin;
        sum      = '0;
        carry    = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = c_run;
            end
            sum[i]   = a[i] ^ b[i] ^ c_run;
            carry[i] = (a[i] & b[i]) | (a[i] & c_run) | (b[i] & c_run);
            c_run    = carry[i];
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle two's-complement adder/subtractor. Operands are accepted in
// IDLE, added CHUNK bits per clock LSB-first in RUN, and the result (with
// flags and optional signed saturation) is presented in DONE.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             subc,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int KW = cnt_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Reject parameter combinations that do not tile the word into chunks.
    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("serial_addsub: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("serial_addsub: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t            state_q;
    logic [KW-1:0]     k_q;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  y_q;      // already conditionally inverted for subtract
    logic              carry_q;  // carry into the current chunk
    logic              sat_q;
    logic [WIDTH-1:0]  s_q;
    logic [WIDTH-1:0]  c_q;
    logic              ovf_q;
    logic              zero_q;
    logic              neg_q;

    logic [31:0]       base;
    logic [CHUNK-1:0]  a_w;
    logic [CHUNK-1:0]  b_w;
    logic [CHUNK-1:0]  sum_w;
    logic [CHUNK-1:0]  carry_w;
    logic              c_msb_in_w;
    logic              last_w;
    logic              ovf_d;
    logic [WIDTH-1:0]  raw_s_d;
    logic [WIDTH-1:0]  raw_c_d;
    logic [WIDTH-1:0]  sat_val;
    logic [WIDTH-1:0]  s_d;

    assign base   = 32'(k_q) * CHUNK;
    assign a_w    = x_q[base +: CHUNK];
    assign b_w    = y_q[base +: CHUNK];
    assign last_w = (k_q == K_LAST);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a        (a_w),
        .b        (b_w),
        .cin      (carry_q),
        .sum      (sum_w),
        .carry    (carry_w),
        .c_msb_in (c_msb_in_w)
    );

    // Merge the current chunk into the held result; untouched chunks keep
    // their previous contents until this operation reaches them.
    always_comb begin
        raw_s_d = s_q;
        raw_c_d = c_q;
        raw_s_d[base +: CHUNK] = sum_w;
        raw_c_d[base +: CHUNK] = carry_w;
    end

    // Overflow is only meaningful on the final chunk, where the adder's top
    // bit is the word's sign bit. Saturation clamps toward the sign of x.
    assign ovf_d   = c_msb_in_w ^ carry_w[CHUNK-1];
    assign sat_val = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign s_d     = (sat_q && ovf_d) ? sat_val : raw_s_d;

    // Control FSM, chunk counter and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        x_q     <= x;
                        y_q     <= y ^ {WIDTH{subc}};
                        carry_q <= subc;
                        sat_q   <= sat;
                        k_q     <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    c_q     <= raw_c_d;
                    carry_q <= carry_w[CHUNK-1];
                    if (last_w) begin
                        s_q     <= s_d;
                        ovf_q   <= ovf_d;
                        zero_q  <= (s_d == '0);
                        neg_q   <= s_d[WIDTH-1];
                        k_q     <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        s_q <= raw_s_d;
                        k_q <= k_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign c         = c_q;
    assign cout      = c_q[WIDTH-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule
